conv2d_param_loader: RTL and testbench

// - Restartable loader for one Conv2D layer's parameters. Reads weight ROM and per-channel quant ROMs, sits between the ROMs and the Conv2D core.
// - Streams weights to the core with a valid/ready handshake and holds bias/m0/n/b/z3 in registers.
// - Replaces the free-running init sequence: start/busy/done control, backpressure, ROM-latency hiding and sizing from parameters.

---
 rtl/conv2d_param_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_conv2d_param_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_param_loader.sv
// conv2d_param_loader: restartable loader for one Conv2D layer's params.
// Ports: clk_i/rst_ni; start_i, busy_o, done_o, params_vld_o control;
// w_rd_*/p_rd_* drive 1-cycle-latency ROMs; kw_* is the weight stream
// (valid/ready); bias_o/m0_o/b_o/n_o per channel, z3_o layer zero point.
module conv2d_param_loader #(
  parameter int F_IN_D      = 1,
  parameter int F_OUT_D     = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int W_RES       = 8,
  parameter int B_RES       = 32,
  parameter int N_RES       = 5,
  parameter int W_ADDRW     = 12,
  parameter int P_ADDRW     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   params_vld_o,
  output logic                   w_rd_en_o,
  output logic [W_ADDRW-1:0]     w_rd_addr_o,
  input  logic [W_RES-1:0]       w_rd_data_i,
  output logic                   p_rd_en_o,
  output logic [P_ADDRW-1:0]     p_rd_addr_o,
  input  logic [B_RES-1:0]       bias_i,
  input  logic [B_RES-1:0]       m0_i,
  input  logic [B_RES-1:0]       b_i,
  input  logic [N_RES-1:0]       n_i,
  input  logic [W_RES-1:0]       z3_i,
  output logic                   kw_valid_o,
  input  logic                   kw_ready_i,
  output logic [W_RES-1:0]       kw_data_o,
  output logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] kw_tap_o,
  output logic [$clog2(F_IN_D):0]  kw_ich_o,
  output logic [$clog2(F_OUT_D):0] kw_och_o,
  output logic                   kw_last_o,
  output logic [B_RES-1:0]       bias_o [F_OUT_D],
  output logic [B_RES-1:0]       m0_o   [F_OUT_D],
  output logic [B_RES-1:0]       b_o    [F_OUT_D],
  output logic [N_RES-1:0]       n_o    [F_OUT_D],
  output logic [W_RES-1:0]       z3_o
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int TAP_W = $clog2(KK);
  localparam int ICH_W = $clog2(F_IN_D) + 1;
  localparam int OCH_W = $clog2(F_OUT_D) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_LOAD_P = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef struct packed {
    logic             last;
    logic [OCH_W-1:0] och;
    logic [ICH_W-1:0] ich;
    logic [TAP_W-1:0] tap;
  } meta_t;

  typedef struct packed {
    meta_t            meta;
    logic [W_RES-1:0] data;
  } beat_t;

  logic [1:0]       state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [ICH_W-1:0] ich_q, ich_d;
  logic [OCH_W-1:0] och_q, och_d;
  logic             all_q, all_d;
  logic             pend_q, pend_d;
  meta_t            pmeta_q, pmeta_d;
  beat_t            fifo_q [2];
  beat_t            fifo_d [2];
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [OCH_W-1:0] pidx_q, pidx_d;
  logic [OCH_W-1:0] pcap_q, pcap_d;
  logic             ppend_q, ppend_d;
  logic [B_RES-1:0] bias_q [F_OUT_D];
  logic [B_RES-1:0] bias_d [F_OUT_D];
  logic [B_RES-1:0] m0_q   [F_OUT_D];
  logic [B_RES-1:0] m0_d   [F_OUT_D];
  logic [B_RES-1:0] b_q    [F_OUT_D];
  logic [B_RES-1:0] b_d    [F_OUT_D];
  logic [N_RES-1:0] n_q    [F_OUT_D];
  logic [N_RES-1:0] n_d    [F_OUT_D];
  logic [W_RES-1:0] z3_q, z3_d;
  logic             done_q, done_d;
  logic             vld_q, vld_d;

  logic             w_iss, last_iss, p_iss;
  logic             kv, acc, push, pop, cap_last;
  beat_t            in_beat, head;
  logic [W_ADDRW-1:0] addr;

  // The returning ROM word is offered directly when the FIFO is empty,
  // so a fresh read reaches the core without an extra register stage.
  always_comb begin
    in_beat.meta = pmeta_q;
    in_beat.data = w_rd_data_i;
    head     = (cnt_q != 2'd0) ? fifo_q[rp_q] : in_beat;
    kv       = (cnt_q != 2'd0) || pend_q;
    acc      = kv && kw_ready_i;
    pop      = acc && (cnt_q != 2'd0);
    push     = pend_q && !(acc && (cnt_q == 2'd0));
    last_iss = (tap_q == TAP_W'(KK-1))
            && (ich_q == ICH_W'(F_IN_D-1))
            && (och_q == OCH_W'(F_OUT_D-1));
    w_iss    = (state_q == S_LOAD_W) && !all_q
            && ((cnt_q + {1'b0, pend_q}) < 2'd2);
    p_iss    = (state_q == S_LOAD_P)
            && (pidx_q < OCH_W'(F_OUT_D));
    cap_last = ppend_q && (pcap_q == OCH_W'(F_OUT_D-1));
    addr     = W_ADDRW'(och_q) * W_ADDRW'(KK*F_IN_D)
             + W_ADDRW'(tap_q) * W_ADDRW'(F_IN_D)
             + W_ADDRW'(ich_q);
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    ich_d   = ich_q;
    och_d   = och_q;
    all_d   = all_q;
    pend_d  = w_iss;
    pmeta_d = pmeta_q;
    fifo_d  = fifo_q;
    wp_d    = wp_q ^ push;
    rp_d    = rp_q ^ pop;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    pidx_d  = pidx_q;
    ppend_d = p_iss;
    pcap_d  = pidx_q;
    bias_d  = bias_q;
    m0_d    = m0_q;
    b_d     = b_q;
    n_d     = n_q;
    z3_d    = z3_q;
    done_d  = 1'b0;
    vld_d   = vld_q;
    if (push) fifo_d[wp_q] = in_beat;
    if (w_iss) begin
      pmeta_d.last = last_iss;
      pmeta_d.och  = och_q;
      pmeta_d.ich  = ich_q;
      pmeta_d.tap  = tap_q;
      tap_d = tap_q + 1'b1;
      if (tap_q == TAP_W'(KK-1)) begin
        tap_d = '0;
        ich_d = ich_q + 1'b1;
        if (ich_q == ICH_W'(F_IN_D-1)) begin
          ich_d = '0;
          och_d = och_q + 1'b1;
          if (och_q == OCH_W'(F_OUT_D-1)) och_d = '0;
        end
      end
      if (last_iss) all_d = 1'b1;
    end
    if (p_iss) pidx_d = pidx_q + 1'b1;
    for (int c = 0; c < F_OUT_D; c++) begin
      if (ppend_q && (pcap_q == OCH_W'(c))) begin
        bias_d[c] = bias_i;
        m0_d[c]   = m0_i;
        b_d[c]    = b_i;
        n_d[c]    = n_i;
      end
    end
    if (ppend_q && (pcap_q == '0)) z3_d = z3_i;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD_W;
          tap_d   = '0;
          ich_d   = '0;
          och_d   = '0;
          all_d   = 1'b0;
          pidx_d  = '0;
          vld_d   = 1'b0;
        end
      end
      S_LOAD_W: begin
        if (acc && head.meta.last) state_d = S_LOAD_P;
      end
      S_LOAD_P: begin
        if (cap_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          vld_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      ich_q   <= '0;
      och_q   <= '0;
      all_q   <= 1'b0;
      pend_q  <= 1'b0;
      pmeta_q <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
      pidx_q  <= '0;
      pcap_q  <= '0;
      ppend_q <= 1'b0;
      for (int c = 0; c < F_OUT_D; c++) begin
        bias_q[c] <= '0;
        m0_q[c]   <= '0;
        b_q[c]    <= '0;
        n_q[c]    <= '0;
      end
      z3_q    <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ich_q   <= ich_d;
      och_q   <= och_d;
      all_q   <= all_d;
      pend_q  <= pend_d;
      pmeta_q <= pmeta_d;
      fifo_q  <= fifo_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      pidx_q  <= pidx_d;
      pcap_q  <= pcap_d;
      ppend_q <= ppend_d;
      bias_q  <= bias_d;
      m0_q    <= m0_d;
      b_q     <= b_d;
      n_q     <= n_d;
      z3_q    <= z3_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
    end
  end

  assign busy_o       = (state_q == S_LOAD_W) || (state_q == S_LOAD_P);
  assign done_o       = done_q;
  assign params_vld_o = vld_q;
  assign w_rd_en_o    = w_iss;
  assign w_rd_addr_o  = w_iss ? addr : '0;
  assign p_rd_en_o    = p_iss;
  assign p_rd_addr_o  = p_iss ? P_ADDRW'(pidx_q) : '0;
  // Payload is forced to zero whenever no beat is offered.
  assign kw_valid_o   = kv;
  assign kw_data_o    = kv ? head.data : '0;
  assign kw_tap_o     = kv ? head.meta.tap : '0;
  assign kw_ich_o     = kv ? head.meta.ich : '0;
  assign kw_och_o     = kv ? head.meta.och : '0;
  assign kw_last_o    = kv && head.meta.last;
  assign bias_o       = bias_q;
  assign m0_o         = m0_q;
  assign b_o          = b_q;
  assign n_o          = n_q;
  assign z3_o         = z3_q;

endmodule

// File: tb/tb_conv2d_param_loader.sv
// tb_conv2d_param_loader: directed + random checks of conv2d_param_loader.
// Two instances: default sizing and F_IN_D=2/F_OUT_D=2.
module tb_conv2d_param_loader;

  localparam int FI = 1;
  localparam int FO = 4;
  localparam int KK = 9;

  typedef struct packed {
    logic       last;
    logic [2:0] och;
    logic [0:0] ich;
    logic [3:0] tap;
    logic [7:0] d;
  } tb_beat_t;

  typedef struct packed {
    logic       last;
    logic [1:0] och;
    logic [1:0] ich;
    logic [3:0] tap;
    logic [7:0] d;
  } tb_beat1_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        start_i = 1'b0;
  logic        busy_o, done_o, params_vld_o;
  logic        w_rd_en_o;
  logic [11:0] w_rd_addr_o;
  logic [7:0]  w_rd_data_i = '0;
  logic        p_rd_en_o;
  logic [7:0]  p_rd_addr_o;
  logic [31:0] bias_i = '0, m0_i = '0, b_i = '0;
  logic [4:0]  n_i = '0;
  logic [7:0]  z3_i = '0;
  logic        kw_valid_o;
  logic        kw_ready_i = 1'b1;
  logic [7:0]  kw_data_o;
  logic [3:0]  kw_tap_o;
  logic [0:0]  kw_ich_o;
  logic [2:0]  kw_och_o;
  logic        kw_last_o;
  logic [31:0] bias_o [FO];
  logic [31:0] m0_o [FO];
  logic [31:0] b_o [FO];
  logic [4:0]  n_o [FO];
  logic [7:0]  z3_o;

  logic [7:0]  wrom [64];
  logic [31:0] brom [FO];
  logic [31:0] mrom [FO];
  logic [31:0] bbrom [FO];
  logic [4:0]  nrom [FO];
  logic [7:0]  z3rom;

  conv2d_param_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .params_vld_o(params_vld_o),
    .w_rd_en_o(w_rd_en_o), .w_rd_addr_o(w_rd_addr_o),
    .w_rd_data_i(w_rd_data_i),
    .p_rd_en_o(p_rd_en_o), .p_rd_addr_o(p_rd_addr_o),
    .bias_i(bias_i), .m0_i(m0_i), .b_i(b_i), .n_i(n_i), .z3_i(z3_i),
    .kw_valid_o(kw_valid_o), .kw_ready_i(kw_ready_i),
    .kw_data_o(kw_data_o), .kw_tap_o(kw_tap_o), .kw_ich_o(kw_ich_o),
    .kw_och_o(kw_och_o), .kw_last_o(kw_last_o),
    .bias_o(bias_o), .m0_o(m0_o), .b_o(b_o), .n_o(n_o), .z3_o(z3_o)
  );

  always @(posedge clk_i) begin
    if (w_rd_en_o) w_rd_data_i <= wrom[w_rd_addr_o[5:0]];
    if (p_rd_en_o) begin
      bias_i <= brom[p_rd_addr_o[1:0]];
      m0_i   <= mrom[p_rd_addr_o[1:0]];
      b_i    <= bbrom[p_rd_addr_o[1:0]];
      n_i    <= nrom[p_rd_addr_o[1:0]];
      z3_i   <= z3rom;
    end
  end

  // Second instance: two input and two output channels.
  logic        start1 = 1'b0;
  logic        busy1, done1, vld1;
  logic        w1_en, p1_en;
  logic [11:0] w1_addr;
  logic [7:0]  w1_data = '0;
  logic [7:0]  p1_addr;
  logic [31:0] z32 = '0;
  logic [4:0]  z5 = '0;
  logic [7:0]  z8 = '0;
  logic        kw1_valid, kw1_last;
  logic        kw1_ready = 1'b1;
  logic [7:0]  kw1_data;
  logic [3:0]  kw1_tap;
  logic [1:0]  kw1_ich, kw1_och;
  logic [31:0] bias1_o [2];
  logic [31:0] m01_o [2];
  logic [31:0] b1_o [2];
  logic [4:0]  n1_o [2];
  logic [7:0]  z31_o;

  conv2d_param_loader #(.F_IN_D(2), .F_OUT_D(2), .KERNEL_SIZE(3)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .params_vld_o(vld1),
    .w_rd_en_o(w1_en), .w_rd_addr_o(w1_addr), .w_rd_data_i(w1_data),
    .p_rd_en_o(p1_en), .p_rd_addr_o(p1_addr),
    .bias_i(z32), .m0_i(z32), .b_i(z32), .n_i(z5), .z3_i(z8),
    .kw_valid_o(kw1_valid), .kw_ready_i(kw1_ready),
    .kw_data_o(kw1_data), .kw_tap_o(kw1_tap), .kw_ich_o(kw1_ich),
    .kw_och_o(kw1_och), .kw_last_o(kw1_last),
    .bias_o(bias1_o), .m0_o(m01_o), .b_o(b1_o), .n_o(n1_o), .z3_o(z31_o)
  );

  always @(posedge clk_i) begin
    if (w1_en) w1_data <= w1_addr[7:0];
  end

  int n_chk = 0;
  int n_fail = 0;
  tb_beat_t got [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_params(input string tag);
    for (int c = 0; c < FO; c++) begin
      chk({tag, "_bias"}, 64'(bias_o[c]), 64'(brom[c]));
      chk({tag, "_m0"}, 64'(m0_o[c]), 64'(mrom[c]));
      chk({tag, "_b"}, 64'(b_o[c]), 64'(bbrom[c]));
      chk({tag, "_n"}, 64'(n_o[c]), 64'(nrom[c]));
    end
    chk({tag, "_z3"}, 64'(z3_o), 64'(z3rom));
    chk({tag, "_vld"}, 64'(params_vld_o), 64'd1);
  endtask

  // One load on the default instance; abort_at>0 returns after that
  // many accepted beats without the end-of-load checks.
  task automatic run_load(input bit rnd, input int restart_at,
                          input int abort_at, input string tag);
    tb_beat_t exp_q [$];
    tb_beat_t e, cur, prev;
    int first_v = -1, dones = 0, k_last = -1, k_done = -1;
    int stall = 0, env = 0, bad = 0, pbad = 0;
    int pa [$];
    bit pv = 1'b0;
    logic vld_k1 = 1'bx, busy_k1 = 1'bx;
    prev = '0;
    got = {};
    for (int o = 0; o < FO; o++)
      for (int i = 0; i < FI; i++)
        for (int t = 0; t < KK; t++) begin
          e.d    = wrom[o*KK*FI + t*FI + i];
          e.tap  = 4'(t);
          e.ich  = 1'(i);
          e.och  = 3'(o);
          e.last = (o == FO-1) && (i == FI-1) && (t == KK-1);
          exp_q.push_back(e);
        end
    @(negedge clk_i);
    start_i = 1'b1;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        start_i = 1'b0;
        vld_k1  = params_vld_o;
        busy_k1 = busy_o;
      end
      if (k == restart_at) start_i = 1'b1;
      if (k == restart_at + 1) start_i = 1'b0;
      kw_ready_i = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
      cur.d = kw_data_o;
      cur.tap = kw_tap_o;
      cur.ich = kw_ich_o;
      cur.och = kw_och_o;
      cur.last = kw_last_o;
      if (pv && !(kw_valid_o && cur == prev)) stall++;
      if ((w_rd_en_o || p_rd_en_o) && !busy_o) env++;
      if (p_rd_en_o) pa.push_back(int'(p_rd_addr_o));
      if (kw_valid_o && first_v < 0) first_v = k;
      if (done_o) begin
        dones++;
        if (k_done < 0) k_done = k;
      end
      pv = kw_valid_o && !kw_ready_i;
      prev = cur;
      if (kw_valid_o && kw_ready_i) begin
        got.push_back(cur);
        if (cur.last) k_last = k;
      end
      if (abort_at > 0 && got.size() == abort_at) return;
      if (k_done >= 0 && k >= k_done + 3) break;
    end
    chk({tag, "_beats"}, 64'(got.size()), 64'(FO*FI*KK));
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    chk({tag, "_seq"}, 64'(bad), 64'd0);
    chk({tag, "_lat"}, 64'(first_v), 64'd2);
    chk({tag, "_dones"}, 64'(dones), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    chk({tag, "_done_ofs"}, 64'(k_done - k_last), 64'(FO + 2));
    if (pa.size() != FO) pbad++;
    for (int i = 0; i < pa.size(); i++) if (pa[i] != i) pbad++;
    chk({tag, "_paddr"}, 64'(pbad), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_rden"}, 64'(env), 64'd0);
    chk({tag, "_vld_k1"}, 64'(vld_k1), 64'd0);
    chk({tag, "_busy_k1"}, 64'(busy_k1), 64'd1);
  endtask

  initial begin
    tb_beat1_t g1 [$];
    tb_beat1_t b1;
    int bad1;
    for (int a = 0; a < 64; a++) wrom[a] = 8'(a);
    brom  = '{32'd10, -32'd20, 32'd30, -32'd40};
    nrom  = '{5'd1, 5'd2, 5'd3, 5'd4};
    z3rom = 8'd5;
    for (int c = 0; c < FO; c++) begin
      mrom[c]  = $urandom;
      bbrom[c] = $urandom;
    end

    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_vld", 64'(params_vld_o), 64'd0);
    chk("rst_kwv", 64'(kw_valid_o), 64'd0);
    chk("rst_wen", 64'(w_rd_en_o | p_rd_en_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_bias0", 64'(bias_o[0]), 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run_load(1'b0, -1, -1, "ramp");
    chk_params("ramp");

    for (int a = 0; a < 64; a++) wrom[a] = 8'($urandom);
    for (int c = 0; c < FO; c++) begin
      brom[c]  = $urandom;
      mrom[c]  = $urandom;
      bbrom[c] = $urandom;
      nrom[c]  = 5'($urandom);
    end
    z3rom = 8'($urandom);
    chk("pre_restart_vld", 64'(params_vld_o), 64'd1);
    run_load(1'b1, 10, -1, "rnd");
    chk_params("rnd");

    run_load(1'b1, -1, 17, "abort");
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_kwv", 64'(kw_valid_o), 64'd0);
    chk("mid_rst_kwd", 64'(kw_data_o), 64'd0);
    chk("mid_rst_wen", 64'(w_rd_en_o), 64'd0);
    chk("mid_rst_vld", 64'(params_vld_o), 64'd0);
    for (int c = 0; c < FO; c++)
      chk("mid_rst_bias", 64'(bias_o[c]), 64'd0);
    chk("mid_rst_z3", 64'(z3_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_load(1'b0, -1, -1, "after_rst");
    chk_params("after_rst");

    @(negedge clk_i);
    start1 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_i);
      if (k == 1) start1 = 1'b0;
      if (kw1_valid) begin
        b1.d = kw1_data;
        b1.tap = kw1_tap;
        b1.ich = kw1_ich;
        b1.och = kw1_och;
        b1.last = kw1_last;
        g1.push_back(b1);
      end
      if (done1) break;
    end
    chk("d1_beats", 64'(g1.size()), 64'd36);
    bad1 = 0;
    for (int o = 0; o < 2; o++)
      for (int i = 0; i < 2; i++)
        for (int t = 0; t < KK; t++) begin
          b1.d = 8'(o*KK*2 + t*2 + i);
          b1.tap = 4'(t);
          b1.ich = 2'(i);
          b1.och = 2'(o);
          b1.last = (o == 1) && (i == 1) && (t == KK-1);
          if (g1.size() <= o*18 + i*9 + t || g1[o*18 + i*9 + t] !== b1)
            bad1++;
        end
    chk("d1_seq", 64'(bad1), 64'd0);
    if (g1.size() > 9) begin
      chk("d1_beat3_addr", 64'(g1[3].d), 64'd6);
      chk("d1_beat3_tap", 64'(g1[3].tap), 64'd3);
      chk("d1_beat9_addr", 64'(g1[9].d), 64'd1);
      chk("d1_beat9_ich", 64'(g1[9].ich), 64'd1);
    end else begin
      chk("d1_short", 64'(g1.size()), 64'd36);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
